// File: rtl/route_task_sequencer.sv
// route_task_sequencer
// Navigation sequencer between the Eco-Center/SAM decoders and the path planner.
// It runs one CSL leg first, then takes SAM pick/place jobs from a small FIFO.
// Each job is issued as two legs (pick, then place). The block counts delivered
// units and, when enabled, aborts a leg that takes too long to arrive.
module route_task_sequencer #(
    parameter int NODE_W      = 5,
    parameter int QDEPTH      = 4,
    parameter int MAX_UNITS   = 3,
    parameter int START_NODE  = 1,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             csl_valid,
    input  logic [NODE_W-1:0]                csl_start,
    input  logic [NODE_W-1:0]                csl_end,
    input  logic [NODE_W-1:0]                csl_prev_end,
    input  logic                             sam_valid,
    output logic                             sam_ready,
    input  logic [NODE_W-1:0]                sam_pick,
    input  logic [NODE_W-1:0]                sam_place,
    input  logic                             arrived,
    input  logic [NODE_W-1:0]                cpu_prev_end,
    input  logic                             abort,
    output logic [NODE_W-1:0]                start_point,
    output logic [NODE_W-1:0]                end_point,
    output logic [NODE_W-1:0]                prev_start,
    output logic                             nav_req,
    output logic                             pick_pulse,
    output logic                             place_pulse,
    output logic [$clog2(QDEPTH):0]          q_count,
    output logic [$clog2(MAX_UNITS+1)-1:0]   units_done,
    output logic                             run_done,
    output logic                             timeout_err
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int UW = $clog2(MAX_UNITS + 1);
    // The leg counter only needs to hold values up to TIMEOUT_CYC-1.
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) + 1 : 1;

    localparam logic [NODE_W-1:0] ZN       = {NODE_W{1'b0}};
    localparam logic [NODE_W-1:0] START_C  = NODE_W'(START_NODE);
    localparam logic [AW-1:0]     ZA       = {AW{1'b0}};
    localparam logic [AW-1:0]     A_ONE    = AW'(1);
    localparam logic [CW-1:0]     ZC       = {CW{1'b0}};
    localparam logic [CW-1:0]     C_ONE    = CW'(1);
    localparam logic [CW-1:0]     QDEPTH_C = CW'(QDEPTH);
    localparam logic [UW-1:0]     ZU       = {UW{1'b0}};
    localparam logic [UW-1:0]     U_ONE    = UW'(1);
    localparam logic [UW-1:0]     MAX_C    = UW'(MAX_UNITS);
    localparam logic [TW-1:0]     ZT       = {TW{1'b0}};
    localparam logic [TW-1:0]     T_ONE    = TW'(1);
    localparam logic [TW-1:0]     TLAST_C  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_WAIT_CSL = 3'd0,
        S_GO_CSL   = 3'd1,
        S_WAIT_JOB = 3'd2,
        S_GO_PICK  = 3'd3,
        S_GO_PLACE = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [NODE_W-1:0]   start_r, start_s;
    logic [NODE_W-1:0]   end_r, end_s;
    logic [NODE_W-1:0]   prev_r, prev_s;
    logic [NODE_W-1:0]   pick_r, pick_s;
    logic [NODE_W-1:0]   place_r, place_s;
    logic [UW-1:0]       units_r, units_s;
    logic                run_done_r, run_done_s;
    logic [TW-1:0]       tmo_cnt_r, tmo_cnt_s;
    logic                nav_req_r, nav_req_s;
    logic                pick_pulse_r, pick_pulse_s;
    logic                place_pulse_r, place_pulse_s;
    logic                timeout_r, timeout_s;

    logic [NODE_W-1:0]   mem_pick_r [QDEPTH];
    logic [NODE_W-1:0]   mem_place_r[QDEPTH];
    logic [AW-1:0]       wr_ptr_r, wr_ptr_s;
    logic [AW-1:0]       rd_ptr_r, rd_ptr_s;
    logic [CW-1:0]       count_r, count_s;
    logic                sam_ready_r, sam_ready_s;

    logic                pop_s;
    logic                push_s;
    logic                flush_s;
    logic                arr_ok_s;
    logic                tmo_hit_s;
    logic [TW-1:0]       tmo_inc_s;
    logic [NODE_W-1:0]   head_pick_s;
    logic [NODE_W-1:0]   head_place_s;

    // An arrival in the same cycle the leg is announced belongs to the previous leg.
    assign arr_ok_s     = arrived && !nav_req_r;
    assign tmo_hit_s    = (TIMEOUT_CYC != 0) && (tmo_cnt_r == TLAST_C);
    assign tmo_inc_s    = (TIMEOUT_CYC != 0) ? (tmo_cnt_r + T_ONE) : tmo_cnt_r;
    assign head_pick_s  = mem_pick_r[rd_ptr_r];
    assign head_place_s = mem_place_r[rd_ptr_r];

    // Next-state and next-output logic of the sequencer FSM.
    always_comb begin
        state_s       = state_r;
        start_s       = start_r;
        end_s         = end_r;
        prev_s        = prev_r;
        pick_s        = pick_r;
        place_s       = place_r;
        units_s       = units_r;
        run_done_s    = run_done_r;
        tmo_cnt_s     = tmo_cnt_r;
        nav_req_s     = 1'b0;
        pick_pulse_s  = 1'b0;
        place_pulse_s = 1'b0;
        timeout_s     = 1'b0;
        pop_s         = 1'b0;
        flush_s       = 1'b0;
        if (abort) begin
            state_s   = S_WAIT_CSL;
            flush_s   = 1'b1;
            start_s   = START_C;
            prev_s    = ZN;
            units_s   = ZU;
            tmo_cnt_s = ZT;
        end else begin
            case (state_r)
                S_WAIT_CSL: begin
                    if (csl_valid) begin
                        end_s      = csl_start;
                        nav_req_s  = 1'b1;
                        run_done_s = 1'b0;
                        units_s    = ZU;
                        tmo_cnt_s  = ZT;
                        state_s    = S_GO_CSL;
                    end else begin
                        state_s = S_WAIT_CSL;
                    end
                end
                S_GO_CSL: begin
                    if (arr_ok_s) begin
                        start_s   = csl_end;
                        prev_s    = csl_prev_end;
                        tmo_cnt_s = ZT;
                        state_s   = S_WAIT_JOB;
                    end else if (tmo_hit_s) begin
                        timeout_s = 1'b1;
                        flush_s   = 1'b1;
                        state_s   = S_WAIT_CSL;
                    end else begin
                        tmo_cnt_s = tmo_inc_s;
                    end
                end
                S_WAIT_JOB: begin
                    // A queued job always wins over a CSL redirect.
                    if (count_r != ZC) begin
                        pop_s     = 1'b1;
                        end_s     = head_pick_s;
                        pick_s    = head_pick_s;
                        place_s   = head_place_s;
                        nav_req_s = 1'b1;
                        tmo_cnt_s = ZT;
                        state_s   = S_GO_PICK;
                    end else if (csl_valid) begin
                        end_s      = csl_start;
                        nav_req_s  = 1'b1;
                        run_done_s = 1'b0;
                        tmo_cnt_s  = ZT;
                        state_s    = S_GO_CSL;
                    end else begin
                        state_s = S_WAIT_JOB;
                    end
                end
                S_GO_PICK: begin
                    if (arr_ok_s) begin
                        pick_pulse_s = 1'b1;
                        start_s      = pick_r;
                        prev_s       = cpu_prev_end;
                        end_s        = place_r;
                        nav_req_s    = 1'b1;
                        tmo_cnt_s    = ZT;
                        state_s      = S_GO_PLACE;
                    end else if (tmo_hit_s) begin
                        timeout_s = 1'b1;
                        flush_s   = 1'b1;
                        state_s   = S_WAIT_CSL;
                    end else begin
                        tmo_cnt_s = tmo_inc_s;
                    end
                end
                S_GO_PLACE: begin
                    if (arr_ok_s) begin
                        place_pulse_s = 1'b1;
                        start_s       = place_r;
                        prev_s        = cpu_prev_end;
                        units_s       = units_r + U_ONE;
                        tmo_cnt_s     = ZT;
                        if (units_s == MAX_C) begin
                            run_done_s = 1'b1;
                            state_s    = S_WAIT_CSL;
                        end else begin
                            state_s = S_WAIT_JOB;
                        end
                    end else if (tmo_hit_s) begin
                        timeout_s = 1'b1;
                        flush_s   = 1'b1;
                        state_s   = S_WAIT_CSL;
                    end else begin
                        tmo_cnt_s = tmo_inc_s;
                    end
                end
                default: begin
                    state_s = S_WAIT_CSL;
                    flush_s = 1'b1;
                end
            endcase
        end
    end

    // FIFO pointer/occupancy update; acceptance uses the registered full flag only.
    always_comb begin
        push_s   = sam_valid && sam_ready_r && !flush_s;
        count_s  = count_r;
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        if (flush_s) begin
            count_s  = ZC;
            wr_ptr_s = ZA;
            rd_ptr_s = ZA;
        end else begin
            if (push_s) begin
                wr_ptr_s = wr_ptr_r + A_ONE;
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = rd_ptr_r + A_ONE;
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + C_ONE;
                2'b01:   count_s = count_r - C_ONE;
                default: count_s = count_r;
            endcase
        end
        sam_ready_s = (count_s < QDEPTH_C);
    end

    // Register all sequencer state, FIFO bookkeeping and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_WAIT_CSL;
            start_r       <= START_C;
            end_r         <= ZN;
            prev_r        <= ZN;
            pick_r        <= ZN;
            place_r       <= ZN;
            units_r       <= ZU;
            run_done_r    <= 1'b0;
            tmo_cnt_r     <= ZT;
            nav_req_r     <= 1'b0;
            pick_pulse_r  <= 1'b0;
            place_pulse_r <= 1'b0;
            timeout_r     <= 1'b0;
            wr_ptr_r      <= ZA;
            rd_ptr_r      <= ZA;
            count_r       <= ZC;
            sam_ready_r   <= 1'b1;
        end else begin
            state_r       <= state_s;
            start_r       <= start_s;
            end_r         <= end_s;
            prev_r        <= prev_s;
            pick_r        <= pick_s;
            place_r       <= place_s;
            units_r       <= units_s;
            run_done_r    <= run_done_s;
            tmo_cnt_r     <= tmo_cnt_s;
            nav_req_r     <= nav_req_s;
            pick_pulse_r  <= pick_pulse_s;
            place_pulse_r <= place_pulse_s;
            timeout_r     <= timeout_s;
            wr_ptr_r      <= wr_ptr_s;
            rd_ptr_r      <= rd_ptr_s;
            count_r       <= count_s;
            sam_ready_r   <= sam_ready_s;
        end
    end

    // Job storage: write the offered pick/place pair at the tail on each push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_pick_r[i]  <= ZN;
                mem_place_r[i] <= ZN;
            end
        end else if (push_s) begin
            mem_pick_r[wr_ptr_r]  <= sam_pick;
            mem_place_r[wr_ptr_r] <= sam_place;
        end
    end

    assign sam_ready   = sam_ready_r;
    assign start_point = start_r;
    assign end_point   = end_r;
    assign prev_start  = prev_r;
    assign nav_req     = nav_req_r;
    assign pick_pulse  = pick_pulse_r;
    assign place_pulse = place_pulse_r;
    assign q_count     = count_r;
    assign units_done  = units_r;
    assign run_done    = run_done_r;
    assign timeout_err = timeout_r;

endmodule
